shift_chain_ctrl: RTL

SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

---
 rtl/shift_chain_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_chain_ctrl.sv
// Serial shift-chain controller: accepts a parallel word and streams it MSB
// first into an external chain of active-low-enable shift cells.
module shift_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    input  logic [WIDTH-1:0] data,
    input  logic             abort,
    output logic             start_ready,
    output logic             chain_in,
    output logic             chain_shift,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             handshake;
    logic             tick;
    logic             advance;
    logic             last_bit;

    assign handshake = start_valid && (state == IDLE);
    assign tick      = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign advance   = tick && !abort;
    assign last_bit  = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tick && last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // abort is the only input allowed to reach chain_shift combinationally
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        chain_in    = 1'b1;
        chain_shift = 1'b1;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
            end
            SHIFT: begin
                busy        = 1'b1;
                chain_in    = sreg[WIDTH-1];
                chain_shift = !advance;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (handshake) begin
            sreg    <= data;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (state == SHIFT && !abort) begin
            if (tick) begin
                sreg    <= {sreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule
